bmem_arbiter: RTL and testbench
===============================

BMEM_ARBITER -- requirements
Module: bmem_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4, beats per cache line on the banked memory port.
REQ-002 Parameter BEAT_W, default 64, bits per beat; line width LINE_W = BURST_LEN*BEAT_W (256).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 i_addr  in  32  I-cache line address; i_read  in  1  I-cache fill request.
REQ-006 i_rdata  out  LINE_W  fill line; i_resp  out  1  one-cycle completion pulse.
REQ-007 d_addr  in  32; d_read  in  1; d_write  in  1; d_wdata  in  LINE_W  D-cache fill/writeback request.
REQ-008 d_rdata  out  LINE_W; d_resp  out  1  one-cycle completion pulse.
REQ-009 bmem_addr  out  32; bmem_read  out  1; bmem_write  out  1; bmem_wdata  out  BEAT_W  memory request side.
REQ-010 bmem_ready  in  1  memory accepts request/beat this cycle; bmem_rdata  in  BEAT_W; bmem_rvalid  in  1  read return beat.

Function
REQ-011 States: IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE; exactly one memory transaction outstanding at any time.
REQ-012 IDLE: when any request is high, grant one client, latch address with bits [4:0] forced to zero, latch d_wdata on a write, then go to RD_REQ (read) or WR_BURST (write).
REQ-013 d_read and d_write both high: the request is treated as a write.
REQ-014 RD_REQ: drive bmem_read=1 and latched address; on bmem_ready=1 go to RD_WAIT; otherwise hold outputs unchanged.
REQ-015 RD_WAIT: each bmem_rvalid beat k (counter 0..BURST_LEN-1) is stored to line bits [BEAT_W*k +: BEAT_W].
REQ-016 RD_WAIT: on beat BURST_LEN-1, go to DONE; the beat counter wraps to 0.
REQ-017 WR_BURST: drive bmem_write=1, latched address, and beat k of latched line; k advances only on bmem_ready=1.
REQ-018 WR_BURST: after beat BURST_LEN-1 is accepted, go to DONE.
REQ-019 DONE: assert resp of the granted client for exactly one cycle; rdata valid that cycle (held until next fill for that client); next state IDLE.
REQ-020 Latency: read resp is the cycle after the last rvalid; write resp is the cycle after the last accepted beat.
REQ-021 No grant occurs in the DONE cycle; the minimum gap between consecutive memory requests is one IDLE cycle.
REQ-022 A client request dropped mid-transaction does not abort; the transaction completes and resp still pulses.
REQ-023 bmem_rvalid outside RD_WAIT is ignored.
REQ-024 bmem_read/bmem_write are never both high; both are low in IDLE, RD_WAIT, and DONE.
REQ-025 The non-granted client's resp stays 0, and its rdata is unchanged.

Reset
REQ-026 On rst=0 (any time, including mid-burst): state IDLE, beat counter 0, bmem_read=bmem_write=0, bmem_addr=0, bmem_wdata=0, i_resp=d_resp=0, i_rdata=d_rdata=0, priority pointer = D-cache.
REQ-027 A transaction interrupted by reset is discarded, with no resp; after release, the first grant is evaluated in the first IDLE cycle.

Configuration
REQ-028 Macro BMEM_ARB_RR_EN defined: round-robin arbitration, with the pointer flipping to the other client after every grant; on a simultaneous request the pointer's client wins, starting with D-cache after reset.
REQ-029 Macro BMEM_ARB_RR_EN undefined: fixed priority, with D-cache always winning simultaneous requests and no pointer state.

Verification
REQ-030 i_read, i_addr=0x1000_0024, ready=1, rvalid beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr=0x1000_0020 for one cycle; i_resp one cycle after the 4th beat; i_rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-031 d_write, d_addr=0x2000_0040, d_wdata beats A,B,C,D, ready low every other cycle -> beats A,B,C,D each held until accepted, addr constant; d_resp the cycle after D is accepted.
REQ-032 i_read and d_read raised in the same cycle, repeated 3 times, RR_EN defined -> grants D,I,D; RR_EN undefined -> grants D,D,D; in both cases the I-cache is served once D drops.
REQ-033 rst=0 pulsed during RD_WAIT after 2 beats -> all outputs 0 immediately (asynchronous); no resp; a new i_read afterward completes normally with fresh data.
REQ-034 Spurious rvalid in IDLE, then d_read=d_write=1 -> stray beat ignored; a write burst is issued, not a read.

Source files
------------

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: I/D-cache line fill/writeback arbiter onto a single-outstanding burst memory port.
// resp pulses one cycle after the last beat; bmem_ready stalls requests/beats; BMEM_ARB_RR_EN selects round-robin over fixed D priority.
module bmem_arbiter #(
  parameter  int BURST_LEN = 4,
  parameter  int BEAT_W    = 64,
  localparam int LINE_W    = BURST_LEN * BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_REQ   = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WR_BURST = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  beat;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] i_line_q;
  logic [LINE_W-1:0] d_line_q;
  logic              gnt_d;

  logic              i_req;
  logic              d_req;
  logic              pick_d;
  logic              is_wr;
  logic [31:0]       req_addr;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef BMEM_ARB_RR_EN
  // ptr_d=1 means the D-cache wins the next simultaneous request.
  logic ptr_d;

  assign pick_d = d_req & (~i_req | ptr_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_d <= 1'b1;
    end else if (state == IDLE && (i_req || d_req)) begin
      ptr_d <= ~pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  // A simultaneous read+write from the D-cache is taken as a write.
  assign is_wr    = pick_d & d_write;
  assign req_addr = pick_d ? d_addr : i_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      beat    <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      gnt_d   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            gnt_d  <= pick_d;
            addr_q <= req_addr & ~32'h0000_001F;
            beat   <= '0;
            if (is_wr) begin
              wline_q <= d_wdata;
              state   <= WR_BURST;
            end else begin
              state   <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (bmem_ready) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bmem_rvalid) begin
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              state <= DONE;
            end else begin
              beat  <= beat + 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              state <= DONE;
            end else begin
              beat  <= beat + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Return beats land directly in the granted client's line register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_line_q <= '0;
      d_line_q <= '0;
    end else if (state == RD_WAIT && bmem_rvalid) begin
      if (gnt_d) d_line_q[BEAT_W*beat +: BEAT_W] <= bmem_rdata;
      else       i_line_q[BEAT_W*beat +: BEAT_W] <= bmem_rdata;
    end
  end

  assign bmem_read  = (state == RD_REQ);
  assign bmem_write = (state == WR_BURST);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? wline_q[BEAT_W*beat +: BEAT_W] : '0;

  assign i_resp  = (state == DONE) & ~gnt_d;
  assign d_resp  = (state == DONE) &  gnt_d;
  assign i_rdata = i_line_q;
  assign d_rdata = d_line_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: fills, writebacks with stalls, arbitration, async reset, stray beats.
module tb_bmem_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  i_addr;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_addr;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks = 0;
  int errors = 0;

  bmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in RD_REQ; leaves the bench sitting in the DONE cycle.
  task automatic serve_read(input logic [255:0] line);
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = line[64*k +: 64];
      tick();
    end
    bmem_rvalid = 1'b0;
    bmem_rdata  = '0;
  endtask

  task automatic serve_write();
    bmem_ready = 1'b1;
    repeat (4) tick();
    bmem_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd"},     {255'd0, bmem_read},  256'd0);
    chk({tag, "_wr"},     {255'd0, bmem_write}, 256'd0);
    chk({tag, "_addr"},   {224'd0, bmem_addr},  256'd0);
    chk({tag, "_wdata"},  {192'd0, bmem_wdata}, 256'd0);
    chk({tag, "_iresp"},  {255'd0, i_resp},     256'd0);
    chk({tag, "_dresp"},  {255'd0, d_resp},     256'd0);
    chk({tag, "_irdata"}, i_rdata,              256'd0);
    chk({tag, "_drdata"}, d_rdata,              256'd0);
  endtask

  logic [255:0] line1, wline, wline2, line_rst, line_new, arb_line;
  logic [63:0]  wbeat;
  logic         exp_d [3];

  initial begin
    line1    = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wline    = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    wline2   = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    line_rst = {64'hDEAD_0004, 64'hDEAD_0003, 64'hDEAD_0002, 64'hDEAD_0001};
    line_new = {64'h5555_0004, 64'h5555_0003, 64'h5555_0002, 64'h5555_0001};
    arb_line = {64'h0A0A_0004, 64'h0A0A_0003, 64'h0A0A_0002, 64'h0A0A_0001};
`ifdef BMEM_ARB_RR_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1;
`endif

    rst = 1'b0;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // I-cache fill, unaligned address, memory always ready.
    i_addr = 32'h1000_0024; i_read = 1'b1;
    tick();
    i_read = 1'b0;
    chk("t1_rd",   {255'd0, bmem_read},  256'd1);
    chk("t1_wr",   {255'd0, bmem_write}, 256'd0);
    chk("t1_addr", {224'd0, bmem_addr},  {224'd0, 32'h1000_0020});
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    chk("t1_rd_wait", {255'd0, bmem_read}, 256'd0);
    chk("t1_addr_gone", {224'd0, bmem_addr}, 256'd0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_noresp_early", {255'd0, i_resp}, 256'd0);
      bmem_rvalid = 1'b1;
      bmem_rdata  = line1[64*k +: 64];
      tick();
    end
    bmem_rvalid = 1'b0;
    chk("t1_iresp",  {255'd0, i_resp}, 256'd1);
    chk("t1_dresp",  {255'd0, d_resp}, 256'd0);
    chk("t1_irdata", i_rdata, line1);
    chk("t1_drdata", d_rdata, 256'd0);
    tick();
    chk("t1_iresp_once", {255'd0, i_resp}, 256'd0);
    chk("t1_irdata_held", i_rdata, line1);

    // D-cache writeback with ready low every other cycle.
    d_addr = 32'h2000_0040; d_wdata = wline; d_write = 1'b1;
    tick();
    d_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wbeat = wline[64*k +: 64];
      bmem_ready = 1'b0;
      chk("t2_wr_stall",    {255'd0, bmem_write}, 256'd1);
      chk("t2_wdata_stall", {192'd0, bmem_wdata}, {192'd0, wbeat});
      chk("t2_addr_stall",  {224'd0, bmem_addr},  {224'd0, 32'h2000_0040});
      tick();
      bmem_ready = 1'b1;
      chk("t2_wdata_acc", {192'd0, bmem_wdata}, {192'd0, wbeat});
      chk("t2_rd_low",    {255'd0, bmem_read},  256'd0);
      chk("t2_noresp",    {255'd0, d_resp},     256'd0);
      tick();
    end
    bmem_ready = 1'b0;
    chk("t2_dresp",     {255'd0, d_resp},     256'd1);
    chk("t2_wr_done",   {255'd0, bmem_write}, 256'd0);
    chk("t2_iresp",     {255'd0, i_resp},     256'd0);
    chk("t2_irdata_kept", i_rdata, line1);
    tick();
    chk("t2_dresp_once", {255'd0, d_resp}, 256'd0);

    // Stray rvalid in IDLE, then read+write together becomes a write.
    bmem_rvalid = 1'b1; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    chk("t3_idle_rd",  {255'd0, bmem_read}, 256'd0);
    chk("t3_drdata",   d_rdata, 256'd0);
    chk("t3_irdata",   i_rdata, line1);
    d_addr = 32'h3000_001F; d_wdata = wline2; d_read = 1'b1; d_write = 1'b1;
    tick();
    d_read = 1'b0; d_write = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = '0;
    chk("t3_wr",    {255'd0, bmem_write}, 256'd1);
    chk("t3_rd",    {255'd0, bmem_read},  256'd0);
    chk("t3_addr",  {224'd0, bmem_addr},  {224'd0, 32'h3000_0000});
    chk("t3_wdata", {192'd0, bmem_wdata}, {192'd0, 64'h0101_0101_0101_0101});
    serve_write();
    chk("t3_dresp",  {255'd0, d_resp}, 256'd1);
    chk("t3_drdata_kept", d_rdata, 256'd0);
    tick();

    // Async reset mid-fill after two beats.
    i_addr = 32'h4000_0000; i_read = 1'b1;
    tick();
    i_read = 1'b0;
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = line_rst[64*k +: 64];
      tick();
    end
    bmem_rvalid = 1'b0; bmem_rdata = '0;
    rst = 1'b0;
    #1;
    check_all_zero("t4_async");
    tick();
    rst = 1'b1;
    tick();
    chk("t4_noresp_i", {255'd0, i_resp}, 256'd0);
    chk("t4_noresp_d", {255'd0, d_resp}, 256'd0);
    chk("t4_idle_rd",  {255'd0, bmem_read}, 256'd0);
    i_addr = 32'h5000_0008; i_read = 1'b1;
    tick();
    i_read = 1'b0;
    chk("t4_new_rd",   {255'd0, bmem_read}, 256'd1);
    chk("t4_new_addr", {224'd0, bmem_addr}, {224'd0, 32'h5000_0000});
    serve_read(line_new);
    chk("t4_new_iresp",  {255'd0, i_resp}, 256'd1);
    chk("t4_new_irdata", i_rdata, line_new);
    tick();

    // Arbitration from a fresh reset: three simultaneous requests.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    i_addr = 32'h6000_0000; d_addr = 32'h7000_0000;
    for (int r = 0; r < 3; r++) begin
      i_read = 1'b1; d_read = 1'b1;
      tick();
      d_read = 1'b0;
      if (r < 2) i_read = 1'b0;
      chk("t5_grant_addr", {224'd0, bmem_addr},
          {224'd0, exp_d[r] ? 32'h7000_0000 : 32'h6000_0000});
      serve_read(arb_line);
      chk("t5_dresp", {255'd0, d_resp}, {255'd0, exp_d[r]});
      chk("t5_iresp", {255'd0, i_resp}, {255'd0, ~exp_d[r]});
      tick();
      chk("t5_no_grant_in_done", {255'd0, bmem_read}, 256'd0);
    end
    // I-cache held its request through the last D grant.
    tick();
    i_read = 1'b0;
    chk("t5_i_after_d_rd",   {255'd0, bmem_read}, 256'd1);
    chk("t5_i_after_d_addr", {224'd0, bmem_addr}, {224'd0, 32'h6000_0000});
    serve_read(line1);
    chk("t5_i_after_d_resp",  {255'd0, i_resp}, 256'd1);
    chk("t5_i_after_d_rdata", i_rdata, line1);
    chk("t5_drdata_arb",      d_rdata, arb_line);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
